// File: rtl/control_unit.sv
// ---------------------------------------------------------------------------
// control_unit
//   Hardwired Moore sequencer for the single-bus Datapath. Runs the T0..T2
//   fetch, decodes the opcode class from ir[31:27] and steps the
//   instruction-specific execute cycles, then returns to T0.
//
// Parameters
//   MEM_WAIT   cycles each memory access holds Read/Write (1..15)
//
// Ports
//   clk        system clock
//   clr        synchronous active-high reset
//   ir         IR contents from the Datapath (only [31:27] decoded)
//   con_ff     branch condition flip-flop; gates PCin in br T6
//   PCout..Cout Datapath control strobes
//   alu_sel    000 ADD, 001 SUB, 010 AND, 011 OR
//   run        low only while halted
//   illegal    one-cycle pulse on an undefined opcode
//   step       (CU_SINGLE_STEP_EN only) advance from WAIT_STEP to T0
//
// Optional build macro
//   CU_SINGLE_STEP_EN  park in WAIT_STEP after every instruction until step
// ---------------------------------------------------------------------------
module control_unit #(
  parameter int unsigned MEM_WAIT = 1
) (
  input  logic        clk,
  input  logic        clr,
`ifdef CU_SINGLE_STEP_EN
  input  logic        step,
`endif
  input  logic [31:0] ir,
  input  logic        con_ff,
  output logic        PCout,
  output logic        MARin,
  output logic        IncPC,
  output logic        Zin,
  output logic        Zlowout,
  output logic        PCin,
  output logic        Read,
  output logic        Write,
  output logic        MDRin,
  output logic        MDRout,
  output logic        IRin,
  output logic        BAout,
  output logic        Yin,
  output logic        Rin,
  output logic        Rout,
  output logic        CONin,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Cout,
  output logic [2:0]  alu_sel,
  output logic        run,
  output logic        illegal
);

  typedef enum logic [3:0] {
    S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
`ifdef CU_SINGLE_STEP_EN
    , S_WAIT_STEP
`endif
  } state_e;

  typedef enum logic [3:0] {
    C_ALU, C_IMM, C_LDI, C_LD, C_ST, C_BR, C_JR, C_NOP, C_HALT, C_ILL
  } cls_e;

  localparam logic [3:0] WAIT_LOAD = 4'(MEM_WAIT - 1);

  state_e     state_q, state_d, done_state;
  cls_e       cls_q, cls_d, dec_cls;
  logic [2:0] alu_q, alu_d, dec_alu;
  logic [3:0] wait_q, wait_d;

  // Only the opcode field is decoded; the register fields belong to the Datapath.
  logic unused_ir_bits;
  assign unused_ir_bits = ^ir[26:0];

`ifdef CU_SINGLE_STEP_EN
  // armed_q drops once a step press is consumed and re-arms when step goes
  // low, so a held step releases only one instruction.
  logic armed_q, armed_d;
  assign done_state = S_WAIT_STEP;
`else
  assign done_state = S_T0;
`endif

  // Opcode decode, consumed at the end of T2.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    dec_cls = C_ILL;
    dec_alu = 3'b000;
    unique case (ir[31:27])
      5'b00011: begin dec_cls = C_ALU; dec_alu = 3'b000; end
      5'b00100: begin dec_cls = C_ALU; dec_alu = 3'b001; end
      5'b00101: begin dec_cls = C_ALU; dec_alu = 3'b010; end
      5'b00110: begin dec_cls = C_ALU; dec_alu = 3'b011; end
      5'b01100: begin dec_cls = C_IMM; dec_alu = 3'b000; end
      5'b01101: begin dec_cls = C_IMM; dec_alu = 3'b010; end
      5'b01110: begin dec_cls = C_IMM; dec_alu = 3'b011; end
      5'b00001: dec_cls = C_LDI;
      5'b00000: dec_cls = C_LD;
      5'b00010: dec_cls = C_ST;
      5'b10010: dec_cls = C_BR;
      5'b10011: dec_cls = C_JR;
      5'b11010: dec_cls = C_NOP;
      5'b11011: dec_cls = C_HALT;
      default:  dec_cls = C_ILL;
    endcase
  end

  // Next state; wait_q reloads when a memory step is entered and the step
  // completes on the cycle it reads zero.
  always_comb begin
    state_d = state_q;
    cls_d   = cls_q;
    alu_d   = alu_q;
    wait_d  = (wait_q != 4'd0) ? wait_q - 4'd1 : 4'd0;
    unique case (state_q)
      S_RST:  state_d = S_T0;
      S_T0:   begin state_d = S_T1; wait_d = WAIT_LOAD; end
      S_T1:   if (wait_q == 4'd0) state_d = S_T2;
      S_T2: begin
        cls_d = dec_cls;
        alu_d = dec_alu;
        unique case (dec_cls)
          C_NOP:   state_d = done_state;
          C_HALT:  state_d = S_HALT;
          default: state_d = S_T3;
        endcase
      end
      S_T3:   state_d = (cls_q inside {C_JR, C_ILL}) ? done_state : S_T4;
      S_T4:   state_d = S_T5;
      S_T5: begin
        if (cls_q inside {C_LD, C_ST, C_BR}) state_d = S_T6;
        else                                 state_d = done_state;
        if (cls_q == C_LD) wait_d = WAIT_LOAD;
      end
      S_T6: begin
        if (cls_q == C_BR) state_d = done_state;
        else if (cls_q == C_ST) begin state_d = S_T7; wait_d = WAIT_LOAD; end
        else if (wait_q == 4'd0) state_d = S_T7;
      end
      S_T7:   if (cls_q == C_LD || wait_q == 4'd0) state_d = done_state;
      S_HALT: state_d = S_HALT;
`ifdef CU_SINGLE_STEP_EN
      S_WAIT_STEP: if (step && armed_q) state_d = S_T0;
`endif
      default: state_d = S_RST;
    endcase
  end

`ifdef CU_SINGLE_STEP_EN
  always_comb begin
    armed_d = armed_q;
    if (!step) armed_d = 1'b1;
    else if (state_q == S_WAIT_STEP && armed_q) armed_d = 1'b0;
  end
`endif

  always_ff @(posedge clk) begin
    // NOTE: sequential state is updated with non-blocking assignments so every flop samples pre-edge values.
    if (clr) begin
      state_q <= S_RST;
      cls_q   <= C_NOP;
      alu_q   <= 3'b000;
      wait_q  <= 4'd0;
`ifdef CU_SINGLE_STEP_EN
      armed_q <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      alu_q   <= alu_d;
      wait_q  <= wait_d;
`ifdef CU_SINGLE_STEP_EN
      armed_q <= armed_d;
`endif
    end
  end

  // Moore outputs; PCin in br T6 is the single input-dependent strobe.
  always_comb begin
    {PCout, MARin, IncPC, Zin, Zlowout, PCin, Read, Write, MDRin, MDRout,
     IRin, BAout, Yin, Rin, Rout, CONin, Gra, Grb, Grc, Cout} = '0;
    alu_sel = 3'b000;
    illegal = 1'b0;
    run     = (state_q != S_HALT);
    unique case (state_q)
      S_T0: begin PCout = 1'b1; MARin = 1'b1; end
      S_T1: begin Read = 1'b1; MDRin = 1'b1; IncPC = (wait_q == WAIT_LOAD); end
      S_T2: begin MDRout = 1'b1; IRin = 1'b1; end
      S_T3: unique case (cls_q)
        C_ALU, C_IMM:      begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
        C_LDI, C_LD, C_ST: begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
        C_BR:              begin Gra = 1'b1; Rout = 1'b1; CONin = 1'b1; end
        C_JR:              begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
        C_ILL:             illegal = 1'b1;
        default: ;
      endcase
      S_T4: unique case (cls_q)
        C_ALU:             begin Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_sel = alu_q; end
        C_IMM:             begin Cout = 1'b1; Zin = 1'b1; alu_sel = alu_q; end
        C_LDI, C_LD, C_ST: begin Cout = 1'b1; Zin = 1'b1; end
        C_BR:              begin PCout = 1'b1; Yin = 1'b1; end
        default: ;
      endcase
      S_T5: unique case (cls_q)
        C_ALU, C_IMM, C_LDI: begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
        C_LD, C_ST:          begin Zlowout = 1'b1; MARin = 1'b1; end
        C_BR:                begin Cout = 1'b1; Zin = 1'b1; end
        default: ;
      endcase
      S_T6: unique case (cls_q)
        C_LD: begin Read = 1'b1; MDRin = 1'b1; end
        C_ST: begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
        C_BR: begin Zlowout = 1'b1; PCin = con_ff; end
        default: ;
      endcase
      S_T7: unique case (cls_q)
        C_LD: begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
        C_ST: Write = 1'b1;
        default: ;
      endcase
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// ---------------------------------------------------------------------------
// tb_control_unit
//   Two control_unit instances (MEM_WAIT=1 and MEM_WAIT=3) share a clock; one
//   is exercised at a time while the other is held in clr. Expected control
//   words come from a per-opcode micro-step table built from the instruction
//   set description.
// ---------------------------------------------------------------------------
module tb_control_unit;

  typedef logic [24:0] word_t;
  typedef word_t wq_t[$];

  // Word layout: [19:0] strobes, [22:20] alu_sel, [23] run, [24] illegal.
  localparam word_t PCOUT  = 25'h0000001, MARIN = 25'h0000002, INCPC = 25'h0000004;
  localparam word_t ZIN    = 25'h0000008, ZLOW  = 25'h0000010, PCIN  = 25'h0000020;
  localparam word_t READ   = 25'h0000040, WRITE = 25'h0000080, MDRIN = 25'h0000100;
  localparam word_t MDROUT = 25'h0000200, IRIN  = 25'h0000400, BAOUT = 25'h0000800;
  localparam word_t YIN    = 25'h0001000, RIN   = 25'h0002000, ROUT  = 25'h0004000;
  localparam word_t CONIN  = 25'h0008000, GRA   = 25'h0010000, GRB   = 25'h0020000;
  localparam word_t GRC    = 25'h0040000, COUT  = 25'h0080000;
  localparam word_t RUN    = 25'h0800000, ILL   = 25'h1000000;
  localparam word_t BUS    = PCOUT | ZLOW | MDROUT | ROUT | BAOUT | COUT;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        clr1 = 1'b1, clr3 = 1'b1;
  logic [31:0] ir1 = '0, ir3 = '0;
  logic        con1 = 1'b0, con3 = 1'b0;
  logic        step1 = 1'b0, step3 = 1'b0;
  logic        sel = 1'b0;
  word_t       w1, w3, obs;

  logic [19:0] s1, s3;
  logic [2:0]  a1, a3;
  logic        r1, r3, i1, i3;

  control_unit #(.MEM_WAIT(1)) dut1 (
    .clk(clk), .clr(clr1),
`ifdef CU_SINGLE_STEP_EN
    .step(step1),
`endif
    .ir(ir1), .con_ff(con1),
    .PCout(s1[0]), .MARin(s1[1]), .IncPC(s1[2]), .Zin(s1[3]), .Zlowout(s1[4]),
    .PCin(s1[5]), .Read(s1[6]), .Write(s1[7]), .MDRin(s1[8]), .MDRout(s1[9]),
    .IRin(s1[10]), .BAout(s1[11]), .Yin(s1[12]), .Rin(s1[13]), .Rout(s1[14]),
    .CONin(s1[15]), .Gra(s1[16]), .Grb(s1[17]), .Grc(s1[18]), .Cout(s1[19]),
    .alu_sel(a1), .run(r1), .illegal(i1)
  );

  control_unit #(.MEM_WAIT(3)) dut3 (
    .clk(clk), .clr(clr3),
`ifdef CU_SINGLE_STEP_EN
    .step(step3),
`endif
    .ir(ir3), .con_ff(con3),
    .PCout(s3[0]), .MARin(s3[1]), .IncPC(s3[2]), .Zin(s3[3]), .Zlowout(s3[4]),
    .PCin(s3[5]), .Read(s3[6]), .Write(s3[7]), .MDRin(s3[8]), .MDRout(s3[9]),
    .IRin(s3[10]), .BAout(s3[11]), .Yin(s3[12]), .Rin(s3[13]), .Rout(s3[14]),
    .CONin(s3[15]), .Gra(s3[16]), .Grb(s3[17]), .Grc(s3[18]), .Cout(s3[19]),
    .alu_sel(a3), .run(r3), .illegal(i3)
  );

  assign w1  = {i1, r1, a1, s1};
  assign w3  = {i3, r3, a3, s3};
  assign obs = sel ? w3 : w1;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  task automatic check(input string tag, input word_t got, input word_t exp);
    checks++;
    assert (got === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic check_bus(input string tag);
    checks++;
    assert ($countones(obs & BUS) <= 1) passes++;
    else begin
      fails++;
      $error("FAIL %s bus: observed=%h expected at most one bus driver", tag, obs & BUS);
    end
  endtask

  function automatic word_t alu(input int v);
    return word_t'(v) << 20;
  endfunction

  // Expected control words, one per clock, for a whole instruction.
  task automatic build(input logic [4:0] op, input bit con, input int mw, output wq_t q);
    q = {};
    q.push_back(RUN | PCOUT | MARIN);
    for (int i = 0; i < mw; i++) q.push_back(RUN | READ | MDRIN | ((i == 0) ? INCPC : '0));
    q.push_back(RUN | MDROUT | IRIN);
    case (op)
      5'd3, 5'd4, 5'd5, 5'd6: begin
        q.push_back(RUN | GRB | ROUT | YIN);
        q.push_back(RUN | GRC | ROUT | ZIN | alu(int'(op) - 3));
        q.push_back(RUN | ZLOW | GRA | RIN);
      end
      5'd12, 5'd13, 5'd14: begin
        q.push_back(RUN | GRB | ROUT | YIN);
        q.push_back(RUN | COUT | ZIN | alu((op == 5'd12) ? 0 : (op == 5'd13) ? 2 : 3));
        q.push_back(RUN | ZLOW | GRA | RIN);
      end
      5'd1, 5'd0, 5'd2: begin
        q.push_back(RUN | GRB | BAOUT | YIN);
        q.push_back(RUN | COUT | ZIN);
        if (op == 5'd1) q.push_back(RUN | ZLOW | GRA | RIN);
        else begin
          q.push_back(RUN | ZLOW | MARIN);
          if (op == 5'd0) begin
            for (int i = 0; i < mw; i++) q.push_back(RUN | READ | MDRIN);
            q.push_back(RUN | MDROUT | GRA | RIN);
          end else begin
            q.push_back(RUN | GRA | ROUT | MDRIN);
            for (int i = 0; i < mw; i++) q.push_back(RUN | WRITE);
          end
        end
      end
      5'd18: begin
        q.push_back(RUN | GRA | ROUT | CONIN);
        q.push_back(RUN | PCOUT | YIN);
        q.push_back(RUN | COUT | ZIN);
        q.push_back(RUN | ZLOW | (con ? PCIN : '0));
      end
      5'd19: q.push_back(RUN | GRA | ROUT | PCIN);
      5'd26: ;
      5'd27: for (int i = 0; i < 20; i++) q.push_back('0);
      default: q.push_back(RUN | ILL);
    endcase
  endtask

  task automatic set_clr(input logic v);
    if (sel) clr3 = v; else clr1 = v;
  endtask

  // Leaves the selected DUT one tick past the edge that enters T0.
  task automatic do_reset(input string tag);
    @(posedge clk); #1 set_clr(1'b1);
    @(posedge clk); #1 set_clr(1'b0);
    @(negedge clk);
    check({tag, " clr cycle"}, obs & ~RUN, '0);
    @(posedge clk); #1;
  endtask

  // Runs one instruction from T0; abort_at >= 0 raises clr during that step.
  task automatic run_instr(input string tag, input logic [31:0] ir_v, input bit con,
                           input int abort_at);
    wq_t q;
    int  mw;
    mw = sel ? 3 : 1;
    build(ir_v[31:27], con, mw, q);
    if (sel) begin ir3 = ir_v; con3 = con; end
    else     begin ir1 = ir_v; con1 = con; end
    for (int k = 0; k < q.size(); k++) begin
      if (k == abort_at) set_clr(1'b1);
      @(negedge clk);
      check($sformatf("%s[%0d]", tag, k), obs, q[k]);
      check_bus($sformatf("%s[%0d]", tag, k));
      @(posedge clk); #1;
      if (k == abort_at) begin
        set_clr(1'b0);
        @(negedge clk);
        check({tag, " aborted"}, obs & ~RUN, '0);
        @(posedge clk); #1;
        break;
      end
    end
  endtask

  task automatic random_run(input string tag, input int n);
    int legal[13] = '{3, 4, 5, 6, 12, 13, 14, 1, 0, 2, 18, 19, 26};
    logic [4:0] op;
    for (int i = 0; i < n; i++) begin
      int pick;
      pick = int'($urandom_range(0, 17));
      if (pick < 13) op = 5'(legal[pick]);
      else           op = 5'($urandom_range(0, 31));
      if (op == 5'd27) op = 5'd31;
      run_instr($sformatf("%s%0d op%0d", tag, i, op), {op, 27'($urandom)}, 1'($urandom_range(0, 1)), -1);
    end
  endtask

  initial begin
    // MEM_WAIT = 1 instance
    sel = 1'b0;
    do_reset("rst1");
    run_instr("add",    32'h18000000, 1'b0, -1);
    run_instr("br_t",   32'h90000000, 1'b1, -1);
    run_instr("br_f",   32'h90000000, 1'b0, -1);
    run_instr("ill",    32'hF8000000, 1'b0, -1);
    run_instr("nop",    32'hD0000000, 1'b0, -1);
    run_instr("halt",   32'hD8000000, 1'b0, -1);
    do_reset("unhalt");
    run_instr("sub",    32'h20000000, 1'b0, -1);
    random_run("r1_", 40);
    @(negedge clk);
    check("t0_tail1", obs, RUN | PCOUT | MARIN);

    // MEM_WAIT = 3 instance
    clr1 = 1'b1;
    sel  = 1'b1;
    do_reset("rst3");
    run_instr("ld3",    32'h00000000, 1'b0, -1);
    run_instr("st3_clr", 32'h10000000, 1'b0, 10);
    run_instr("st3",    32'h10000000, 1'b0, -1);
    run_instr("ori3",   32'h70000000, 1'b0, -1);
    random_run("r3_", 40);
    @(negedge clk);
    check("t0_tail3", obs, RUN | PCOUT | MARIN);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
